// File: rtl/cpu_ex_muldiv.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiplier and
// restoring divider (one bit per cycle) writing architectural HI/LO registers.
module cpu_ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_stall,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic                 op_signed_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   fix_prod_s;
  logic [WIDTH-1:0]     fix_quo_s;
  logic [WIDTH-1:0]     fix_rem_s;

  // Operand magnitudes for the signed variants.
  assign op_signed_s = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg_s     = op_signed_s & a[WIDTH-1];
  assign b_neg_s     = op_signed_s & b[WIDTH-1];
  assign a_mag_s     = neg_w(a, a_neg_s);
  assign b_mag_s     = neg_w(b, b_neg_s);

  // Multiply: acc holds {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Divide: acc holds {remainder, dividend/quotient}; the shifted remainder needs WIDTH+1 bits.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, mcand_q};
  assign div_next_s  = div_diff_s[WIDTH]
                     ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff_s[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign fix_prod_s = neg_2w(acc_q, neg_quo_q);
  assign fix_quo_s  = neg_w(acc_q[WIDTH-1:0], neg_quo_q);
  assign fix_rem_s  = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  // Next-state and register update logic; stall freezes everything, flush aborts.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (cpu_stall) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_d = a;
              OP_MTLO: lo_d = a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                busy_d   = 1'b1;
                cnt_d    = CNT_INIT;
                is_div_d = op[1];
                if (op[1] && (b == {WIDTH{1'b0}})) begin
                  // Divide by zero bypasses RUN: raw dividend to HI, all ones to LO.
                  acc_d     = {a, {WIDTH{1'b1}}};
                  mcand_d   = b;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = ST_FIX;
                end else if (op[1]) begin
                  acc_d     = {{WIDTH{1'b0}}, a_mag_s};
                  mcand_d   = b_mag_s;
                  neg_quo_d = a_neg_s ^ b_neg_s;
                  neg_rem_d = a_neg_s;
                  state_d   = ST_RUN;
                end else begin
                  acc_d     = {{WIDTH{1'b0}}, b_mag_s};
                  mcand_d   = a_mag_s;
                  neg_quo_d = a_neg_s ^ b_neg_s;
                  neg_rem_d = 1'b0;
                  state_d   = ST_RUN;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (is_div_q) begin
            hi_d = fix_rem_s;
            lo_d = fix_quo_s;
          end else begin
            hi_d = fix_prod_s[2*WIDTH-1:WIDTH];
            lo_d = fix_prod_s[WIDTH-1:0];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_cpu_ex_muldiv.sv
// Self-checking bench for cpu_ex_muldiv: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_cpu_ex_muldiv;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         cpu_stall;
  logic         flush;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_cmp;
  int           n_err;
  int           cyc;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  cpu_ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall), .flush(flush), .start(start),
    .op(op), .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    eh = exp_hi;
    el = exp_lo;
    case (o)
      3'd0: begin p = sa * sb; {eh, el} = p; end
      3'd1: begin up = {32'h0, av} * {32'h0, bv}; {eh, el} = up; end
      3'd2, 3'd3: begin
        if (bv == 32'h0) begin
          eh = av; el = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          el = 32'(sa / sb); eh = 32'(sa % sb);
        end else begin
          el = av / bv; eh = av % bv;
        end
      end
      3'd4: eh = av;
      3'd5: el = av;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input string tag);
    logic [W-1:0] eh, el;
    int exp_k, done_k, busy_cnt;
    model_op(o, av, bv, eh, el);
    exp_k = (o[1] && bv == 32'h0) ? 2 : W + 2;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    done_k = 0; busy_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_k = k; break; end
    end
    check_val({tag, "/latency"}, 64'(done_k), 64'(exp_k));
    check_val({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_k - 1));
    check_val({tag, "/hi"}, 64'(hi), 64'(eh));
    check_val({tag, "/lo"}, 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    check_val({tag, "/done_pulse"}, 64'(done), 64'(0));
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [W-1:0] av, input string tag);
    logic [W-1:0] eh, el;
    model_op(o, av, 32'h0, eh, el);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom;
    @(negedge clk);
    check_val({tag, "/hi"}, 64'(hi), 64'(eh));
    check_val({tag, "/lo"}, 64'(lo), 64'(el));
    check_val({tag, "/busy"}, 64'(busy), 64'(0));
    check_val({tag, "/done"}, 64'(done), 64'(0));
    exp_hi = eh;
    exp_lo = el;
  endtask

  function automatic logic [W-1:0] pick_val(input int sel);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen, dcnt, e0, lat;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    n_cmp = 0; n_err = 0; cyc = 0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    rst = 1'b0; cpu_stall = 1'b0; flush = 1'b0; start = 1'b0;
    op = 3'd0; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clk);
    check_val("reset/hi", 64'(hi), 64'(0));
    check_val("reset/lo", 64'(lo), 64'(0));
    check_val("reset/busy", 64'(busy), 64'(0));
    check_val("reset/done", 64'(done), 64'(0));
    @(posedge clk); #2;
    rst = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(3'd2, 32'h1234_5678, 32'h0, "div_by_zero");
    run_op(3'd3, 32'hCAFE_F00D, 32'h0, "divu_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    mt_op(3'd6, 32'h1111_2222, "noop6");
    mt_op(3'd7, 32'h3333_4444, "noop7");

    // Flush mid-RUN: partial result discarded, HI/LO untouched.
    mt_op(3'd4, 32'h0BAD_BEEF, "pre_flush_mthi");
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_val("flush/busy", 64'(busy), 64'(0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check_val("flush/no_done", 64'(seen), 64'(0));
    check_val("flush/hi", 64'(hi), 64'(exp_hi));
    check_val("flush/lo", 64'(lo), 64'(exp_lo));
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

    // Stall mid-RUN and while done is high; start during busy is ignored.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; e0 = cyc;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; cpu_stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 cpu_stall = 1'b0;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin lat = cyc - e0 + 1; break; end
    end
    check_val("stall/latency", 64'(lat), 64'(W + 7));
    cpu_stall = 1'b1;
    dcnt = (lat != 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    cpu_stall = 1'b0;
    @(negedge clk);
    check_val("stall/done_width", 64'(dcnt), 64'(3));
    check_val("stall/done_drop", 64'(done), 64'(0));
    check_val("stall/hi", 64'(hi), 64'(0));
    check_val("stall/lo", 64'(lo), 64'(42));
    exp_hi = 32'h0; exp_lo = 32'd42;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_val($urandom_range(0, 9));
      rb = pick_val($urandom_range(0, 9));
      if (ro < 3'd4) run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
      else mt_op(ro, ra, $sformatf("rand%0d_op%0d", i, ro));
    end

    // Asynchronous reset in the middle of a divide.
    mt_op(3'd4, 32'h1357_9BDF, "pre_reset_mthi");
    mt_op(3'd5, 32'h2468_ACE0, "pre_reset_mtlo");
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("async_rst/busy", 64'(busy), 64'(0));
    check_val("async_rst/done", 64'(done), 64'(0));
    check_val("async_rst/hi", 64'(hi), 64'(0));
    check_val("async_rst/lo", 64'(lo), 64'(0));
    exp_hi = 32'h0; exp_lo = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    mt_op(3'd4, 32'hA5A5_A5A5, "mthi_after_rst");
    mt_op(3'd5, 32'h5A5A_5A5A, "mtlo_after_rst");
    run_op(3'd1, 32'd3, 32'd4, "multu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
